aes128_core: RTL and testbench
==============================

Name: aes128_core

Overview:
- Top-level AES-128 block. Expands a 128-bit key into 11 round keys, encrypts one 128-bit plaintext block, then decrypts the resulting ciphertext as a round-trip check.
- Runs back-to-back jobs continuously with no handshake, re-sampling inputs at the start of every job.
- Sits between the key/plaintext sources and the file-writer path; `file_in` is carried alongside each job so results can be paired downstream.

Parameters:
- None. AES-128 only: Nk=4, Nr=10.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- key  input  128  cipher key.
- plain_text  input  128  block to encrypt.
- file_in  input  128  tag word from the file RAM, captured with the job.
- file_out  output  128  `file_in` value belonging to the job currently shown on the outputs.
- expanded_key  output  1408  round keys 0..10.
- cipher_text  output  128  AES-128 encryption of the captured `plain_text`.
- decrypted_plain_text  output  128  inverse cipher of `cipher_text`; must equal the captured `plain_text`.

Behaviour:
- Byte order: block byte k = bits [8k+7:8k].
  - State is column-major: byte k sits at row k%4, column k/4.
  - Key word w[i] = bits [32i+31:32i], with byte 0 of the word in the low bits.
- expanded_key layout: round key r = bits [128r+127:128r]; round key 0 = key.
- Reset (rst=0, asynchronous): FSM goes to CAPTURE; every output register and internal register clears to 0.
- Reset during an active job aborts it; nothing partial ever reaches the outputs.
- FSM states and sequence:
  - CAPTURE (1 cycle): register `key`, `plain_text` and `file_in`; round-key 0 = key.
  - EXPAND (10 cycles): cycle i produces round key i using RotWord, SubWord and Rcon = 01,02,04,08,10,20,40,80,1B,36.
  - ENC (10 cycles): initial AddRoundKey(rk0) is applied on entry. Rounds 1-9 are SubBytes, ShiftRows, MixColumns, AddRoundKey. Round 10 omits MixColumns.
  - DEC (10 cycles): standard inverse cipher using round keys 10 down to 0 (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns). The last round omits InvMixColumns.
  - UPDATE (1 cycle): `cipher_text`, `decrypted_plain_text`, `expanded_key` and `file_out` all load simultaneously. The FSM then returns to CAPTURE.
- Latency and period:
  - 32 cycles from the CAPTURE edge to the UPDATE edge.
  - New results every 32 cycles.
  - Outputs hold constant between UPDATE edges.
- Input changes outside CAPTURE are ignored until the next job.
- First valid outputs appear 32 cycles after reset release; all outputs read 0 before that.
- One round per cycle. A single 4-lane SubWord S-box is shared between EXPAND and ENC. SubBytes uses 16 lanes; InvSubBytes uses 16 lanes.
- S-box and inverse S-box tables come from the shared `aes_sbox` / `aes_inv_sbox` lookup modules. `xtime` and GF(2^8) multiplies (x2, x3, x9, x11, x13, x14) are combinational functions inside this block.
- No X propagation: undriven or floating inputs in the bench are captured as-is, and the datapath never self-loops on X.

Test Plan:
1. FIPS-197 vector.
   - Stimulus: key=128'h0f0e0d0c0b0a09080706050403020100, plain_text=128'hffeeddccbbaa99887766554433221100.
   - Required: cipher_text=128'h5ac5b47080b7cdd830047b6ad8e0c469; decrypted_plain_text equals plain_text.
2. Key schedule, same key as scenario 1.
   - Required: expanded_key[127:0]=key; expanded_key[1407:1280]=128'hc5302b4d8ba707f3174a94e37f1d1113.
3. Latency.
   - Stimulus: release rst, then count rising edges.
   - Required: all outputs 0 for the first 31 edges; valid results at edge 32; the next update at edge 64.
4. Input change mid-job.
   - Stimulus: change plain_text at cycle 5 of a job.
   - Required: that job's cipher_text reflects the old block; the following job reflects the new block.
5. Async reset mid-job.
   - Stimulus: pull rst low during ENC, off the clock edge.
   - Required: outputs go to 0 immediately; after release, a full 32-cycle job produces correct results.
6. Round-trip sweep and tag tracking.
   - Stimulus: key=128'h100F0E0D0C0B0A090807060504030201, plain_text=128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1 through 128'h100F0E0D0C0B0A090807060504030201, with file_in = an incrementing tag.
   - Required: decrypted_plain_text equals plain_text for every block; cipher_text matches a software model; file_out equals the tag captured for that job.

Source files
------------

// File: rtl/aes128_core.sv
// AES-128 core: expands the key, encrypts one block and decrypts it again, one round per cycle.
// All results are published together on one edge, every 32 cycles.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    // Entry 0 is the leftmost byte of the literal, so entry a lives at packed index 255-a.
    localparam logic [255:0][7:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y_o = TABLE[~a_i];
endmodule

module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [255:0][7:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign y_o = TABLE[~a_i];
endmodule

module aes128_core (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  key,
    input  logic [127:0]  plain_text,
    input  logic [127:0]  file_in,
    output logic [127:0]  file_out,
    output logic [1407:0] expanded_key,
    output logic [127:0]  cipher_text,
    output logic [127:0]  decrypted_plain_text
);
    typedef enum logic [2:0] {CAPTURE, EXPAND, ENC, DEC, UPDATE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [10:0][127:0]  rk_q;
    logic [127:0]        data_q, ct_q, tag_q;
    logic [127:0]        cipher_q, plain_q, file_q;
    logic [1407:0]       expkey_q;

    logic [127:0] sb_in, sb_out, inv_out, shifted, mixed, enc_out;
    logic [127:0] inv_shift, dec_ark, dec_out, prev_key, next_key;
    logic [31:0]  rot_word, temp, w0, w1, w2, w3;
    logic [3:0]   prev_idx;
    logic         last_round;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = b;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) acc ^= p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Both matrices are circulant, so each output row is the same four products rotated.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [31:0] res;
        logic [3:0]  m0, m1, m2, m3;
        m0 = inv ? 4'd14 : 4'd2;
        m1 = inv ? 4'd11 : 4'd3;
        m2 = inv ? 4'd13 : 4'd1;
        m3 = inv ? 4'd9  : 4'd1;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            res[8*r +: 8] = gmul(col[8*r +: 8], m0) ^ gmul(col[8*((r+1)%4) +: 8], m1)
                          ^ gmul(col[8*((r+2)%4) +: 8], m2) ^ gmul(col[8*((r+3)%4) +: 8], m3);
        end
        return res;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign last_round = (rnd_q == 4'd10);
    assign prev_idx   = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
    assign prev_key   = rk_q[prev_idx];
    assign rot_word   = {prev_key[103:96], prev_key[127:104]};

    // Lanes 0..3 double as the key-schedule SubWord while expanding.
    assign sb_in    = (state_q == EXPAND) ? {data_q[127:32], rot_word} : data_q;
    assign temp     = sb_out[31:0] ^ {24'h0, rcon(rnd_q)};
    assign w0       = prev_key[31:0]   ^ temp;
    assign w1       = prev_key[63:32]  ^ w0;
    assign w2       = prev_key[95:64]  ^ w1;
    assign w3       = prev_key[127:96] ^ w2;
    assign next_key = {w3, w2, w1, w0};

    for (genvar k = 0; k < 16; k++) begin : g_lane
        aes_sbox     u_sbox     (.a_i(sb_in[8*k +: 8]),  .y_o(sb_out[8*k +: 8]));
        aes_inv_sbox u_inv_sbox (.a_i(data_q[8*k +: 8]), .y_o(inv_out[8*k +: 8]));
    end

    always_comb begin
        shifted   = '0;
        inv_shift = '0;
        mixed     = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shifted[8*(r+4*c) +: 8]   = sb_out[8*(r+4*((c+r)%4)) +: 8];
                inv_shift[8*(r+4*c) +: 8] = inv_out[8*(r+4*((c+4-r)%4)) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) mixed[32*c +: 32] = mix_column(shifted[32*c +: 32], 1'b0);
        enc_out = (last_round ? shifted : mixed) ^ rk_q[rnd_q];
        dec_ark = inv_shift ^ rk_q[4'd10 - rnd_q];
        dec_out = dec_ark;
        if (!last_round) begin
            for (int c = 0; c < 4; c++) dec_out[32*c +: 32] = mix_column(dec_ark[32*c +: 32], 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CAPTURE;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        case (state_q)
            CAPTURE: begin
                state_d = EXPAND;
                rnd_d   = 4'd1;
            end
            EXPAND, ENC, DEC: begin
                if (last_round) begin
                    state_d = (state_q == EXPAND) ? ENC : (state_q == ENC) ? DEC : UPDATE;
                    rnd_d   = (state_q == DEC) ? 4'd0 : 4'd1;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            UPDATE: begin
                state_d = CAPTURE;
                rnd_d   = 4'd0;
            end
            default: begin
                state_d = CAPTURE;
                rnd_d   = 4'd0;
            end
        endcase
    end

    // The last encryption round stores the pre-AddRoundKey state, which is exactly ct ^ rk10,
    // so decryption starts without a separate initial key addition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk_q     <= '0;
            data_q   <= '0;
            ct_q     <= '0;
            tag_q    <= '0;
            cipher_q <= '0;
            plain_q  <= '0;
            file_q   <= '0;
            expkey_q <= '0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    rk_q[0] <= key;
                    data_q  <= plain_text ^ key;
                    tag_q   <= file_in;
                end
                EXPAND: rk_q[rnd_q] <= next_key;
                ENC: begin
                    if (last_round) begin
                        ct_q   <= enc_out;
                        data_q <= shifted;
                    end else begin
                        data_q <= enc_out;
                    end
                end
                DEC: data_q <= dec_out;
                UPDATE: begin
                    cipher_q <= ct_q;
                    plain_q  <= data_q;
                    file_q   <= tag_q;
                    expkey_q <= rk_q;
                end
                default: ;
            endcase
        end
    end

    assign cipher_text          = cipher_q;
    assign decrypted_plain_text = plain_q;
    assign file_out             = file_q;
    assign expanded_key         = expkey_q;
endmodule

// File: tb/tb_aes128_core.sv
// Directed bench for aes128_core: FIPS-197 vector, latency/period, mid-job input change,
// async reset abort and a round-trip sweep against an independently derived AES model.

module tb_aes128_core;
    localparam logic [127:0] FIPS_KEY  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FIPS_PT   = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] FIPS_CT   = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] FIPS_RK10 = 128'hc5302b4d8ba707f3174a94e37f1d1113;
    localparam logic [127:0] SWEEP_KEY = 128'h100F0E0D0C0B0A090807060504030201;
    localparam logic [127:0] TAG_A     = 128'hA0A0_0001;
    localparam logic [127:0] TAG_B     = 128'hB0B0_0002;
    localparam logic [127:0] TAG_C     = 128'hC0C0_0003;
    localparam logic [127:0] TAG_D     = 128'hD0D0_0004;
    localparam logic [127:0] P2        = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] P3        = 128'h3243f6a8885a308d313198a2e0370734;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  key, plain_text, file_in;
    logic [127:0]  file_out, cipher_text, decrypted_plain_text;
    logic [1407:0] expanded_key;

    int checks = 0;
    int fails  = 0;
    logic [7:0] sboxTb [256];

    aes128_core dut (
        .clk                  (clk),
        .rst                  (rst),
        .key                  (key),
        .plain_text           (plain_text),
        .file_in              (file_in),
        .file_out             (file_out),
        .expanded_key         (expanded_key),
        .cipher_text          (cipher_text),
        .decrypted_plain_text (decrypted_plain_text)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] tbXtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tbMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = tbXtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box derived from the field inverse plus affine map, not copied from a table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (tbMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxTb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] modelKeys(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[7:0], t[31:8]};
                t  = {sboxTb[t[31:24]], sboxTb[t[23:16]], sboxTb[t[15:8]], sboxTb[t[7:0]]} ^ {24'h0, rc};
                rc = tbXtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) res[32*i +: 32] = w[i];
        return res;
    endfunction

    function automatic logic [127:0] modelEncrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [1407:0] rks;
        logic [7:0]    s [4][4];
        logic [7:0]    t [4][4];
        logic [7:0]    a0, a1, a2, a3;
        logic [127:0]  res;
        rks = modelKeys(k);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[8*(r+4*c) +: 8] ^ rks[8*(r+4*c) +: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sboxTb[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
                if (rd < 10) begin
                    s[0][c] = tbXtime(a0) ^ tbXtime(a1) ^ a1 ^ a2 ^ a3;
                    s[1][c] = a0 ^ tbXtime(a1) ^ tbXtime(a2) ^ a2 ^ a3;
                    s[2][c] = a0 ^ a1 ^ tbXtime(a2) ^ tbXtime(a3) ^ a3;
                    s[3][c] = tbXtime(a0) ^ a0 ^ a1 ^ a2 ^ tbXtime(a3);
                end else begin
                    s[0][c] = a0; s[1][c] = a1; s[2][c] = a2; s[3][c] = a3;
                end
            end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] ^= rks[128*rd + 8*(r+4*c) +: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[8*(r+4*c) +: 8] = s[r][c];
        return res;
    endfunction

    task automatic test_reset();
        rst        = 1'b0;
        key        = FIPS_KEY;
        plain_text = FIPS_PT;
        file_in    = TAG_A;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cipher_text !== 128'h0) begin
            fails++; $display("[TB] FAIL reset_cipher: got %h expected 0", cipher_text);
        end
        checks++;
        if (decrypted_plain_text !== 128'h0) begin
            fails++; $display("[TB] FAIL reset_plain: got %h expected 0", decrypted_plain_text);
        end
        checks++;
        if (file_out !== 128'h0) begin
            fails++; $display("[TB] FAIL reset_file_out: got %h expected 0", file_out);
        end
        checks++;
        if (expanded_key !== 1408'h0) begin
            fails++; $display("[TB] FAIL reset_expanded_key: low word %h, expected all zero", expanded_key[127:0]);
        end
    endtask

    task automatic test_fips_latency();
        int firstBad;
        logic [1407:0] expKeys;
        int badRk;
        expKeys = modelKeys(FIPS_KEY);
        @(negedge clk);
        rst      = 1'b1;
        firstBad = 0;
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk);
            #1;
            if (firstBad == 0 && {cipher_text, decrypted_plain_text, file_out, expanded_key} !== '0) firstBad = e;
        end
        checks++;
        if (firstBad != 0) begin
            fails++; $display("[TB] FAIL latency_early_zero: outputs nonzero at edge %0d, expected zero through edge 31", firstBad);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cipher_text !== FIPS_CT) begin
            fails++; $display("[TB] FAIL fips_cipher: got %h expected %h", cipher_text, FIPS_CT);
        end
        checks++;
        if (decrypted_plain_text !== FIPS_PT) begin
            fails++; $display("[TB] FAIL fips_roundtrip: got %h expected %h", decrypted_plain_text, FIPS_PT);
        end
        checks++;
        if (expanded_key[127:0] !== FIPS_KEY) begin
            fails++; $display("[TB] FAIL rk0: got %h expected %h", expanded_key[127:0], FIPS_KEY);
        end
        checks++;
        if (expanded_key[1407:1280] !== FIPS_RK10) begin
            fails++; $display("[TB] FAIL rk10: got %h expected %h", expanded_key[1407:1280], FIPS_RK10);
        end
        badRk = -1;
        for (int r = 10; r >= 0; r--) if (expanded_key[128*r +: 128] !== expKeys[128*r +: 128]) badRk = r;
        checks++;
        if (badRk >= 0) begin
            fails++; $display("[TB] FAIL key_schedule: rk%0d got %h expected %h", badRk,
                              expanded_key[128*badRk +: 128], expKeys[128*badRk +: 128]);
        end
        checks++;
        if (file_out !== TAG_A) begin
            fails++; $display("[TB] FAIL fips_tag: got %h expected %h", file_out, TAG_A);
        end
    endtask

    task automatic test_next_update();
        int firstBad;
        file_in  = TAG_B;
        firstBad = 0;
        for (int e = 33; e <= 63; e++) begin
            @(posedge clk);
            #1;
            if (firstBad == 0 && (file_out !== TAG_A || cipher_text !== FIPS_CT)) firstBad = e;
        end
        checks++;
        if (firstBad != 0) begin
            fails++; $display("[TB] FAIL output_hold: outputs changed at edge %0d, file_out %h expected %h", firstBad, file_out, TAG_A);
        end
        @(posedge clk);
        #1;
        checks++;
        if (file_out !== TAG_B) begin
            fails++; $display("[TB] FAIL second_update_tag: got %h expected %h at edge 64", file_out, TAG_B);
        end
        checks++;
        if (cipher_text !== FIPS_CT) begin
            fails++; $display("[TB] FAIL second_update_cipher: got %h expected %h", cipher_text, FIPS_CT);
        end
    endtask

    task automatic test_input_change();
        logic [127:0] expP2;
        expP2      = modelEncrypt(FIPS_KEY, P2);
        plain_text = FIPS_PT;
        file_in    = TAG_C;
        repeat (5) @(posedge clk);
        #1;
        plain_text = P2;
        repeat (27) @(posedge clk);
        #1;
        checks++;
        if (cipher_text !== FIPS_CT) begin
            fails++; $display("[TB] FAIL midjob_old_cipher: got %h expected %h", cipher_text, FIPS_CT);
        end
        checks++;
        if (decrypted_plain_text !== FIPS_PT) begin
            fails++; $display("[TB] FAIL midjob_old_plain: got %h expected %h", decrypted_plain_text, FIPS_PT);
        end
        repeat (32) @(posedge clk);
        #1;
        checks++;
        if (cipher_text !== expP2) begin
            fails++; $display("[TB] FAIL midjob_new_cipher: got %h expected %h", cipher_text, expP2);
        end
        checks++;
        if (decrypted_plain_text !== P2) begin
            fails++; $display("[TB] FAIL midjob_new_plain: got %h expected %h", decrypted_plain_text, P2);
        end
    endtask

    task automatic test_async_reset();
        int firstBad;
        logic [127:0] expP3;
        expP3 = modelEncrypt(FIPS_KEY, P3);
        repeat (14) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        checks++;
        if ({cipher_text, decrypted_plain_text, file_out, expanded_key} !== '0) begin
            fails++; $display("[TB] FAIL async_reset_clear: cipher %h file_out %h expected 0", cipher_text, file_out);
        end
        plain_text = P3;
        file_in    = TAG_D;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        firstBad = 0;
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk);
            #1;
            if (firstBad == 0 && {cipher_text, decrypted_plain_text, file_out, expanded_key} !== '0) firstBad = e;
        end
        checks++;
        if (firstBad != 0) begin
            fails++; $display("[TB] FAIL abort_no_partial: outputs nonzero at edge %0d after release", firstBad);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cipher_text !== expP3) begin
            fails++; $display("[TB] FAIL post_reset_cipher: got %h expected %h", cipher_text, expP3);
        end
        checks++;
        if (decrypted_plain_text !== P3) begin
            fails++; $display("[TB] FAIL post_reset_plain: got %h expected %h", decrypted_plain_text, P3);
        end
        checks++;
        if (file_out !== TAG_D) begin
            fails++; $display("[TB] FAIL post_reset_tag: got %h expected %h", file_out, TAG_D);
        end
    endtask

    task automatic test_round_trip_sweep();
        logic [127:0] pt, tag, expCt;
        key = SWEEP_KEY;
        for (int j = 0; j <= 16; j++) begin
            for (int k = 0; k < 16; k++) pt[8*k +: 8] = 8'hF1 + 8'(k) + 8'(j);
            tag        = 128'h5EED_0000 + 128'(j);
            plain_text = pt;
            file_in    = tag;
            expCt      = modelEncrypt(SWEEP_KEY, pt);
            repeat (32) @(posedge clk);
            #1;
            checks++;
            if (decrypted_plain_text !== pt) begin
                fails++; $display("[TB] FAIL sweep_plain[%0d]: got %h expected %h", j, decrypted_plain_text, pt);
            end
            checks++;
            if (cipher_text !== expCt) begin
                fails++; $display("[TB] FAIL sweep_cipher[%0d]: got %h expected %h", j, cipher_text, expCt);
            end
            checks++;
            if (file_out !== tag) begin
                fails++; $display("[TB] FAIL sweep_tag[%0d]: got %h expected %h", j, file_out, tag);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        build_sbox();
        $display("[TB] starting aes128_core directed tests");
        test_reset();
        test_fips_latency();
        test_next_update();
        test_input_change();
        test_async_reset();
        test_round_trip_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
